reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 17 +
 rtl/reg_file_rf_read_port.sv | 60 ++++++
 rtl/reg_file.sv | 102 ++++++++++
 tb/tb_reg_file.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared processor defines for the 64-bit datapath blocks: default register
// width, register index width and the hard-wired zero register index.
// -----------------------------------------------------------------------------
package reg_file_pkg;

    localparam int RF_DATA_W   = 64;   // datapath register width
    localparam int RF_ADDR_W   = 5;    // register index width
    localparam int RF_ZERO_REG = 0;    // index that always reads as zero

    // Number of architectural registers for a given index width.
    function automatic int rf_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage : reg_file_pkg

// File: rtl/reg_file_rf_read_port.sv
// -----------------------------------------------------------------------------
// rf_read_port
// One registered read port of the register file. Samples its address on the
// rising edge, forwards a same-cycle write to the same index, forces the zero
// register to read 0, and holds its output while stalled.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   stall        1 = hold rd_data
//   rd_addr      read index
//   arr_data     current array contents at rd_addr (from reg_file)
//   wr_en/wr_addr/wr_data   write port, used for the bypass compare
//   rd_data      registered read data
// -----------------------------------------------------------------------------
module rf_read_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] arr_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic              w_is_zero;
    logic              w_bypass;
    logic [DATA_W-1:0] w_next;
    logic [DATA_W-1:0] r_data;

    assign w_is_zero = (rd_addr == ADDR_W'(RF_ZERO_REG));
    // A write to index 0 is never forwarded: the zero check wins first.
    assign w_bypass  = wr_en && (wr_addr == rd_addr);

    always_comb begin
        w_next = arr_data;
        if (w_is_zero) begin
            w_next = '0;
        end else if (w_bypass) begin
            w_next = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (!stall) begin
            r_data <= w_next;
        end
    end

    assign rd_data = r_data;

endmodule : rf_read_port

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// 2**ADDR_W x DATA_W register file with two registered read ports (1-cycle
// latency, write-through bypass) and one write port. Register 0 reads as 0.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   stall                  1 = read outputs and rd_valid hold; writes proceed
//   rd_addr_a, rd_addr_b   read indices
//   wr_en, wr_addr, wr_data write port
//   rd_data_a, rd_data_b   registered read data
//   rd_valid               outputs hold a completed read
// -----------------------------------------------------------------------------
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid
);

    localparam int DEPTH = rf_depth(ADDR_W);

    logic [DATA_W-1:0] w_regs [DEPTH];
    logic [DATA_W-1:0] w_arr_a;
    logic [DATA_W-1:0] w_arr_b;
    logic              r_valid;

    // Every register is cleared by the asynchronous reset, so the array is
    // built from individual flops rather than a RAM.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
        if (gi == RF_ZERO_REG) begin : g_zero
            assign w_regs[gi] = '0;
        end else begin : g_store
            logic [DATA_W-1:0] r_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
                    r_q <= wr_data;
                end
            end
            assign w_regs[gi] = r_q;
        end
    end

    assign w_arr_a = w_regs[rd_addr_a];
    assign w_arr_b = w_regs[rd_addr_b];

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .rd_addr  (rd_addr_a),
        .arr_data (w_arr_a),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data_a)
    );

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .rd_addr  (rd_addr_b),
        .arr_data (w_arr_b),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data_b)
    );

    // Sticky after the first unstalled edge out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_valid <= 1'b1;
        end
    end

    assign rd_valid = r_valid;

endmodule : reg_file

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file
// Directed vector table, hand-written reset/stall sequences and randomized
// traffic against an array-based reference model of the register file.
// -----------------------------------------------------------------------------
module tb_reg_file;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NREG = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic [AW-1:0] rd_addr_a = '0;
    logic [AW-1:0] rd_addr_b = '0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] rd_data_b;
    logic          rd_valid;

    int errors = 0;
    int checks = 0;

    // Reference model: architectural register contents and visible outputs.
    logic [DW-1:0] m_regs [NREG];
    logic [DW-1:0] m_a;
    logic [DW-1:0] m_b;
    logic          m_v;

    typedef struct {
        logic          s;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
        logic          exp_v;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    reg_file dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .rd_valid  (rd_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        m_a = '0;
        m_b = '0;
        m_v = 1'b0;
    endtask

    // Value a read of index ra returns in a cycle with the given write.
    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] ra, input logic we,
                                                 input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        if (ra == 0) return '0;
        if (we && wa == ra) return wd;
        return m_regs[ra];
    endfunction

    // Apply one cycle of inputs, advance past the edge, update the model.
    task automatic step(input logic s, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                        input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        stall = s; rd_addr_a = ra; rd_addr_b = rb;
        wr_en = we; wr_addr = wa; wr_data = wd;
        @(posedge clk);
        #1;
        if (!s) begin
            m_a = model_read(ra, we, wa, wd);
            m_b = model_read(rb, we, wa, wd);
            m_v = 1'b1;
        end
        if (we && wa != 0) m_regs[wa] = wd;
        wr_en = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, " rd_data_a"}, rd_data_a, m_a);
        check({tag, " rd_data_b"}, rd_data_b, m_b);
        check({tag, " rd_valid"}, DW'(rd_valid), DW'(m_v));
    endtask

    initial begin
        logic [DW-1:0] all_ones;
        all_ones = '1;

        //             s   ra  rb  we  wa  wd        exp_a  exp_b  exp_v
        vecs[0] = '{1'b0, 0, 0, 1'b1, 5, 4213,     0,     0,     1'b1};
        vecs[1] = '{1'b0, 5, 5, 1'b0, 0, 0,        4213,  4213,  1'b1};
        vecs[2] = '{1'b0, 5, 0, 1'b1, 7, 1,        4213,  0,     1'b1};
        vecs[3] = '{1'b0, 5, 7, 1'b1, 7, 69230,    4213,  69230, 1'b1};
        vecs[4] = '{1'b0, 0, 7, 1'b1, 0, all_ones, 0,     69230, 1'b1};
        vecs[5] = '{1'b0, 0, 0, 1'b0, 0, 0,        0,     0,     1'b1};
        vecs[6] = '{1'b0, 5, 7, 1'b0, 0, 0,        4213,  69230, 1'b1};
        vecs[7] = '{1'b1, 7, 0, 1'b1, 5, 99,       4213,  69230, 1'b1};
        vecs[8] = '{1'b1, 3, 3, 1'b0, 0, 0,        4213,  69230, 1'b1};
        vecs[9] = '{1'b0, 5, 5, 1'b0, 0, 0,        99,    99,    1'b1};

        model_reset();

        // Reset held across clock edges.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset rd_data_a", rd_data_a, '0);
        check("reset rd_data_b", rd_data_b, '0);
        check("reset rd_valid", DW'(rd_valid), '0);

        // Release between edges; valid rises on the next edge.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release pre-edge rd_valid", DW'(rd_valid), '0);
        step(1'b0, 0, 0, 1'b0, 0, 0);
        check("release post-edge rd_valid", DW'(rd_valid), 1);

        // Directed vector table.
        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].s, vecs[i].ra, vecs[i].rb, vecs[i].we, vecs[i].wa, vecs[i].wd);
            check($sformatf("vec%0d rd_data_a", i), rd_data_a, vecs[i].exp_a);
            check($sformatf("vec%0d rd_data_b", i), rd_data_b, vecs[i].exp_b);
            check($sformatf("vec%0d rd_valid", i), DW'(rd_valid), DW'(vecs[i].exp_v));
        end

        // Randomized traffic against the model; narrow address range
        // sometimes to provoke bypass and same-address reads.
        for (int i = 0; i < 400; i++) begin
            logic          s;
            logic [AW-1:0] ra, rb, wa;
            logic          we;
            logic [DW-1:0] wd;
            logic          narrow;
            narrow = ($urandom_range(0, 1) == 1);
            s  = ($urandom_range(0, 7) == 0);
            ra = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NREG - 1));
            rb = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NREG - 1));
            wa = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NREG - 1));
            we = ($urandom_range(0, 2) != 0);
            wd = {$urandom, $urandom};
            step(s, ra, rb, we, wa, wd);
            check_outputs($sformatf("rand%0d", i));
        end

        // Async reset mid-run: make r5 known, then drop rst_n between edges.
        step(1'b0, 5, 5, 1'b1, 5, 64'h1234_5678_9abc_def0);
        step(1'b0, 5, 5, 1'b0, 0, 0);
        check("pre-async r5", rd_data_a, 64'h1234_5678_9abc_def0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async rd_data_a", rd_data_a, '0);
        check("async rd_data_b", rd_data_b, '0);
        check("async rd_valid", DW'(rd_valid), '0);
        // A write on an edge while reset is low must be lost.
        wr_en = 1'b1; wr_addr = 5; wr_data = 64'd777;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 5, 5, 1'b0, 0, 0);
        check_outputs("post-async read r5");

        // Reset asserted during a stall, released while still stalled.
        step(1'b0, 0, 0, 1'b1, 9, 64'd55);
        step(1'b0, 9, 9, 1'b0, 0, 0);
        check("pre-stall-reset r9", rd_data_b, 64'd55);
        stall = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("stall-reset rd_data_a", rd_data_a, '0);
        check("stall-reset rd_valid", DW'(rd_valid), '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 9, 9, 1'b0, 0, 0);
        check("stalled after release rd_valid", DW'(rd_valid), '0);
        step(1'b0, 9, 9, 1'b0, 0, 0);
        check_outputs("unstall after reset");
        check("unstall rd_valid", DW'(rd_valid), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_reg_file
